// File: rtl/dual_rail_pkg.sv
// Shared types and sizing constants for the dual-rail sweep checker.
package dual_rail_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/dual_rail_sweep_checker_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 while enabled and flags
// the final cycle of the hold, which is the sample cycle.
module hold_timer
    import dual_rail_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [CNT_W-1:0] cnt_reg;

    assign last = (cnt_reg == CNT_W'(HOLD_CYCLES - 1));

    // Wrap to zero after the sample cycle so the next vector starts a fresh hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= last ? '0 : cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dual_rail_sweep_checker.sv
// Dual-rail self-test sequencer: walks all 16 input vectors on true and
// complement rails, samples the circuit output at the end of each hold and
// accumulates captured response, mismatch count and first failing index.
module dual_rail_sweep_checker
    import dual_rail_pkg::*;
#(
    parameter int          HOLD_CYCLES = 20,
    parameter logic [15:0] EXPECTED    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dut_out,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        not_a,
    output logic        not_b,
    output logic        not_c,
    output logic        not_d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail,
    output logic        fail_valid
);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [15:0]        captured_reg, captured_next;
    logic [4:0]         mismatch_reg, mismatch_next;
    logic [IDX_W-1:0]   first_fail_reg, first_fail_next;
    logic               fail_valid_reg, fail_valid_next;
    logic               timer_clear;
    logic               timer_enable;
    logic               timer_last;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .enable(timer_enable),
        .last  (timer_last)
    );

    // State, vector index and result registers; reset discards any partial sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            captured_reg   <= '0;
            mismatch_reg   <= '0;
            first_fail_reg <= '0;
            fail_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            captured_reg   <= captured_next;
            mismatch_reg   <= mismatch_next;
            first_fail_reg <= first_fail_next;
            fail_valid_reg <= fail_valid_next;
        end
    end

    // Sequencing and result accumulation; sampling only on the last hold cycle.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        captured_next   = captured_reg;
        mismatch_next   = mismatch_reg;
        first_fail_next = first_fail_reg;
        fail_valid_next = fail_valid_reg;
        timer_clear     = 1'b0;
        timer_enable    = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                // Keep the timer parked at zero so a new sweep starts cleanly.
                timer_clear = 1'b1;
                if (start) begin
                    state_next      = RUN;
                    idx_next        = '0;
                    captured_next   = '0;
                    mismatch_next   = '0;
                    first_fail_next = '0;
                    fail_valid_next = 1'b0;
                end
            end
            RUN: begin
                timer_enable = 1'b1;
                if (timer_last) begin
                    captured_next[idx_reg] = dut_out;
                    if (dut_out != EXPECTED[idx_reg]) begin
                        mismatch_next   = mismatch_reg + 5'd1;
                        fail_valid_next = 1'b1;
                        if (!fail_valid_reg) begin
                            first_fail_next = idx_reg;
                        end
                    end
                    // The last vector stays on the rails while results are held.
                    if (idx_reg == IDX_W'(NUM_VECTORS - 1)) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Rails decode straight from the index register, so both polarities
    // change together on the clock edge with no combinational hazard.
    assign a     = idx_reg[3];
    assign b     = idx_reg[2];
    assign c     = idx_reg[1];
    assign d     = idx_reg[0];
    assign not_a = ~idx_reg[3];
    assign not_b = ~idx_reg[2];
    assign not_c = ~idx_reg[1];
    assign not_d = ~idx_reg[0];

    assign busy           = (state_reg == RUN);
    assign done           = (state_reg == DONE);
    assign pass           = (state_reg == DONE) && (mismatch_reg == 5'd0);
    assign captured       = captured_reg;
    assign mismatch_count = mismatch_reg;
    assign first_fail     = first_fail_reg;
    assign fail_valid     = fail_valid_reg;

endmodule

// File: tb/tb_dual_rail_sweep_checker.sv
// Self-checking bench: three checker instances (hold 20, 3 and 1) each drive a
// behavioural circuit-under-test whose truth table is EXPECTED xor a fault mask.
module tb_dual_rail_sweep_checker;

    localparam logic [15:0] EXP = 16'hA5C3;

    logic        clk;
    logic        rst;
    logic        start_s      [3];
    logic        dut_out_s    [3];
    logic        a_s          [3];
    logic        b_s          [3];
    logic        c_s          [3];
    logic        d_s          [3];
    logic        not_a_s      [3];
    logic        not_b_s      [3];
    logic        not_c_s      [3];
    logic        not_d_s      [3];
    logic        busy_s       [3];
    logic        done_s       [3];
    logic        pass_s       [3];
    logic [15:0] captured_s   [3];
    logic [4:0]  mm_s         [3];
    logic [3:0]  ff_s         [3];
    logic        fv_s         [3];
    logic [15:0] resp_s       [3];

    int n_vec;
    int n_err;

    function automatic int hold_of(input int n);
        return (n == 0) ? 20 : ((n == 1) ? 3 : 1);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        dual_rail_sweep_checker #(
            .HOLD_CYCLES(gi == 0 ? 20 : (gi == 1 ? 3 : 1)),
            .EXPECTED   (EXP)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .start         (start_s[gi]),
            .dut_out       (dut_out_s[gi]),
            .a             (a_s[gi]),
            .b             (b_s[gi]),
            .c             (c_s[gi]),
            .d             (d_s[gi]),
            .not_a         (not_a_s[gi]),
            .not_b         (not_b_s[gi]),
            .not_c         (not_c_s[gi]),
            .not_d         (not_d_s[gi]),
            .busy          (busy_s[gi]),
            .done          (done_s[gi]),
            .pass          (pass_s[gi]),
            .captured      (captured_s[gi]),
            .mismatch_count(mm_s[gi]),
            .first_fail    (ff_s[gi]),
            .fail_valid    (fv_s[gi])
        );
        // Circuit under test: looks up its response from the true rails.
        assign dut_out_s[gi] = resp_s[gi][{a_s[gi], b_s[gi], c_s[gi], d_s[gi]}];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_reset(input int n, input string tag);
        logic [11:0] got;
        got = {a_s[n], b_s[n], c_s[n], d_s[n], not_a_s[n], not_b_s[n], not_c_s[n],
               not_d_s[n], busy_s[n], done_s[n], pass_s[n], fv_s[n]};
        n_vec++;
        if (got !== 12'b0000_1111_0000) begin
            n_err++;
            $display("FAIL %s inst%0d rails/flags got %b want %b", tag, n, got, 12'b0000_1111_0000);
        end
        n_vec++;
        if (captured_s[n] !== 16'h0000) begin
            n_err++;
            $display("FAIL %s inst%0d captured got %h want 0000", tag, n, captured_s[n]);
        end
        n_vec++;
        if (mm_s[n] !== 5'd0) begin
            n_err++;
            $display("FAIL %s inst%0d mismatch_count got %0d want 0", tag, n, mm_s[n]);
        end
        n_vec++;
        if (ff_s[n] !== 4'd0) begin
            n_err++;
            $display("FAIL %s inst%0d first_fail got %0d want 0", tag, n, ff_s[n]);
        end
    endtask

    // One full sweep on instance n with the given fault mask; every cycle is
    // checked against the results implied by the samples taken so far.
    // ignore_t >= 0 pulses start mid-sweep, which must have no effect.
    task automatic run_sweep(input int n, input logic [15:0] mask, input int ignore_t,
                             input string tag);
        int          h;
        int          nsamp;
        int          errs_before;
        logic [31:0] low;
        logic [15:0] exp_cap;
        logic [15:0] exp_bad;
        logic [4:0]  exp_mm;
        logic [3:0]  exp_ff;
        logic [3:0]  exp_idx;
        logic [3:0]  exp_flags;
        logic [7:0]  got_rails;
        logic [3:0]  got_flags;
        h = hold_of(n);
        errs_before = n_err;
        resp_s[n] = EXP ^ mask;
        @(negedge clk);
        start_s[n] = 1'b1;
        for (int t = 0; t <= 16 * h; t++) begin
            @(negedge clk);
            nsamp   = t / h;
            low     = (32'd1 << nsamp) - 32'd1;
            exp_cap = resp_s[n] & low[15:0];
            exp_bad = mask & low[15:0];
            exp_mm  = 5'($countones(exp_bad));
            exp_ff  = 4'd0;
            for (int i = 15; i >= 0; i--) begin
                if (exp_bad[i]) exp_ff = 4'(i);
            end
            exp_idx   = (t < 16 * h) ? 4'(t / h) : 4'd15;
            exp_flags = {(t < 16 * h), (t == 16 * h), (t == 16 * h) && (exp_mm == 5'd0),
                         (exp_bad != 16'h0)};
            got_rails = {a_s[n], b_s[n], c_s[n], d_s[n], not_a_s[n], not_b_s[n],
                         not_c_s[n], not_d_s[n]};
            got_flags = {busy_s[n], done_s[n], pass_s[n], fv_s[n]};
            n_vec++;
            if (got_rails !== {exp_idx, ~exp_idx}) begin
                n_err++;
                $display("FAIL %s rails t=%0d got %b want %b", tag, t, got_rails, {exp_idx, ~exp_idx});
            end
            n_vec++;
            if (got_flags !== exp_flags) begin
                n_err++;
                $display("FAIL %s busy/done/pass/fail_valid t=%0d got %b want %b", tag, t,
                         got_flags, exp_flags);
            end
            n_vec++;
            if (captured_s[n] !== exp_cap) begin
                n_err++;
                $display("FAIL %s captured t=%0d got %h want %h", tag, t, captured_s[n], exp_cap);
            end
            n_vec++;
            if (mm_s[n] !== exp_mm) begin
                n_err++;
                $display("FAIL %s mismatch_count t=%0d got %0d want %0d", tag, t, mm_s[n], exp_mm);
            end
            if (exp_bad != 16'h0) begin
                n_vec++;
                if (ff_s[n] !== exp_ff) begin
                    n_err++;
                    $display("FAIL %s first_fail t=%0d got %0d want %0d", tag, t, ff_s[n], exp_ff);
                end
            end
            start_s[n] = (t == ignore_t) && (t + 1 < 16 * h);
        end
        start_s[n] = 1'b0;
        $display("sweep %-12s inst%0d hold=%0d mask=%h captured=%h mismatches=%0d first_fail=%0d pass=%0b errors=%0d",
                 tag, n, h, mask, captured_s[n], mm_s[n], ff_s[n], pass_s[n], n_err - errs_before);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int n = 0; n < 3; n++) check_reset(n, "reset_held");
        rst = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 3; n++) check_reset(n, "reset_released");
        $display("reset check done");
    endtask

    task automatic test_correct();
        repeat (3) @(negedge clk);
        run_sweep(0, 16'h0000, -1, "correct");
    endtask

    task automatic test_stuck_at_0();
        run_sweep(0, EXP, -1, "stuck_at_0");
    endtask

    task automatic test_single_fault();
        run_sweep(0, 16'h0200, -1, "single_fault");
    endtask

    task automatic test_busy_start_ignored();
        run_sweep(0, 16'($urandom), 50, "start_ignored");
    endtask

    task automatic test_rails_hold3();
        run_sweep(1, 16'($urandom), -1, "hold3_a");
        run_sweep(1, 16'($urandom), 7, "hold3_b");
    endtask

    task automatic test_hold1();
        run_sweep(2, 16'h0000, -1, "hold1_clean");
        run_sweep(2, 16'($urandom), 5, "hold1_rand");
    endtask

    task automatic test_reset_mid();
        resp_s[0] = EXP;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (99) @(negedge clk);
        n_vec++;
        if (busy_s[0] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid busy before reset got %b want 1", busy_s[0]);
        end
        rst = 1'b1;
        #1;
        check_reset(0, "reset_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset(0, "reset_mid_after");
        $display("mid-sweep reset check done");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            run_sweep(1, 16'($urandom), -1, "back_to_back");
        end
        run_sweep(0, 16'($urandom), -1, "restart_rand");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int n = 0; n < 3; n++) begin
            start_s[n] = 1'b0;
            resp_s[n]  = EXP;
        end
        test_reset();
        test_correct();
        test_stuck_at_0();
        test_single_fault();
        test_busy_start_ignored();
        test_rails_hold3();
        test_hold1();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
